// File: rtl/snf_rxreq.sv
// SN-F REQ-channel receiver: grants L-credits to the HN-F, accepts
// ReadNoSnp flits into a credit-sized FIFO and presents them to memory.
package snf_pkg;

  typedef struct packed {
    logic [6:0]  tgtid;
    logic [6:0]  srcid;
    logic [7:0]  txnid;
    logic [6:0]  returnnid;
    logic [5:0]  opcode;
    logic [2:0]  size;
    logic [47:0] addr;
    logic        expcompack;
  } reqflit_t;

  typedef struct packed {
    logic [47:0] addr;
    logic [2:0]  size;
    logic [7:0]  txnid;
    logic [6:0]  srcid;
    logic [6:0]  returnnid;
    logic        expcompack;
  } memreq_t;

  localparam logic [5:0] OP_LCRDRETURN = 6'h00;
  localparam logic [5:0] OP_READNOSNP  = 6'h04;

endpackage

module snf_rxreq
  import snf_pkg::*;
#(
  parameter int         NUM_CREDITS = 4,
  parameter logic [6:0] SNF_ID      = 7'h20
) (
  input  logic        clock,
  input  logic        reset,
  input  reqflit_t    RXREQFLIT,
  input  logic        RXREQFLITV,
  input  logic        RXREQFLITPEND,
  output logic        RXREQLCRDV,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [47:0] mem_req_addr,
  output logic [2:0]  mem_req_size,
  output logic [7:0]  mem_req_txnid,
  output logic [6:0]  mem_req_srcid,
  output logic [6:0]  mem_req_returnnid,
  output logic        mem_req_expcompack,
  output logic        err_credit,
  output logic        err_tgtid,
  output logic        err_opcode,
  output logic [3:0]  credits_out
);

  localparam int PW = (NUM_CREDITS > 1) ?
                      $clog2(NUM_CREDITS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_CREDITS - 1);
  localparam logic [4:0]    LIMIT = 5'(NUM_CREDITS);

  logic [3:0]    tx_credits;
  logic [3:0]    tx_next;
  logic [3:0]    count;
  logic [3:0]    count_next;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          lcrdv_next;

  logic has_credit;
  logic consume;
  logic is_return;
  logic bad_tgt;
  logic bad_op;
  logic push;
  logic pop;

  memreq_t fifo_mem [NUM_CREDITS];
  memreq_t wr_entry;
  memreq_t head;

  logic unused_pend;
  assign unused_pend = RXREQFLITPEND;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // A grant seen this cycle is not yet usable by a same-cycle flit.
  always_comb begin
    has_credit = (tx_credits != 4'd0);
    consume    = RXREQFLITV & has_credit;
    is_return  = (RXREQFLIT.opcode == OP_LCRDRETURN);
    bad_tgt    = !is_return &
                 (RXREQFLIT.tgtid != SNF_ID);
    bad_op     = !is_return & !bad_tgt &
                 ((RXREQFLIT.opcode != OP_READNOSNP) |
                  (RXREQFLIT.size == 3'd7));
    push       = consume & !is_return &
                 !bad_tgt & !bad_op;
    pop        = (count != 4'd0) & mem_req_ready;
  end

  always_comb begin
    tx_next    = tx_credits + 4'(RXREQLCRDV) - 4'(consume);
    count_next = count + 4'(push) - 4'(pop);
    lcrdv_next = ({1'b0, tx_next} + {1'b0, count_next})
                 < LIMIT;
  end

  always_comb begin
    wr_entry.addr       = RXREQFLIT.addr;
    wr_entry.size       = RXREQFLIT.size;
    wr_entry.txnid      = RXREQFLIT.txnid;
    wr_entry.srcid      = RXREQFLIT.srcid;
    wr_entry.returnnid  = RXREQFLIT.returnnid;
    wr_entry.expcompack = RXREQFLIT.expcompack;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_credits <= 4'd0;
      count      <= 4'd0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      RXREQLCRDV <= 1'b0;
      err_credit <= 1'b0;
      err_tgtid  <= 1'b0;
      err_opcode <= 1'b0;
    end else begin
      tx_credits <= tx_next;
      count      <= count_next;
      RXREQLCRDV <= lcrdv_next;
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      err_credit <= RXREQFLITV & !has_credit;
      err_tgtid  <= consume & bad_tgt;
      err_opcode <= consume & bad_op;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= wr_entry;
  end

  assign head = fifo_mem[rd_ptr];

  always_comb begin
    mem_req_valid      = (count != 4'd0);
    mem_req_addr       = head.addr;
    mem_req_size       = head.size;
    mem_req_txnid      = head.txnid;
    mem_req_srcid      = head.srcid;
    mem_req_returnnid  = head.returnnid;
    mem_req_expcompack = head.expcompack;
    credits_out        = tx_credits;
  end

endmodule

// File: tb/tb_snf_rxreq.sv
// Directed bench for snf_rxreq with a scoreboard of
// expected memory requests checked at each pop.
module tb_snf_rxreq;
  import snf_pkg::*;

  logic        clock;
  logic        reset;
  reqflit_t    flit;
  logic        flitv;
  logic        flitpend;
  logic        lcrdv;
  logic        valid;
  logic        ready;
  logic [47:0] addr;
  logic [2:0]  size;
  logic [7:0]  txnid;
  logic [6:0]  srcid;
  logic [6:0]  rnid;
  logic        eca;
  logic        e_cred;
  logic        e_tgt;
  logic        e_op;
  logic [3:0]  credits;

  int ncmp;
  int nfail;
  memreq_t sb[$];

  snf_rxreq #(.NUM_CREDITS(4), .SNF_ID(7'h20)) dut (
    .clock              (clock),
    .reset              (reset),
    .RXREQFLIT          (flit),
    .RXREQFLITV         (flitv),
    .RXREQFLITPEND      (flitpend),
    .RXREQLCRDV         (lcrdv),
    .mem_req_valid      (valid),
    .mem_req_ready      (ready),
    .mem_req_addr       (addr),
    .mem_req_size       (size),
    .mem_req_txnid      (txnid),
    .mem_req_srcid      (srcid),
    .mem_req_returnnid  (rnid),
    .mem_req_expcompack (eca),
    .err_credit         (e_cred),
    .err_tgtid          (e_tgt),
    .err_opcode         (e_op),
    .credits_out        (credits)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [6:0]  tgt,
                      input logic [5:0]  opc,
                      input logic [2:0]  sz,
                      input logic [7:0]  txn,
                      input logic [47:0] a,
                      input logic [6:0]  rn,
                      input logic        ea,
                      input logic        exp_push);
    memreq_t e;
    flit.tgtid      = tgt;
    flit.srcid      = 7'h01;
    flit.txnid      = txn;
    flit.returnnid  = rn;
    flit.opcode     = opc;
    flit.size       = sz;
    flit.addr       = a;
    flit.expcompack = ea;
    flitv = 1'b1;
    if (exp_push) begin
      e.addr       = a;
      e.size       = sz;
      e.txnid      = txn;
      e.srcid      = 7'h01;
      e.returnnid  = rn;
      e.expcompack = ea;
      sb.push_back(e);
    end
    step();
    flitv = 1'b0;
  endtask

  // Credits must ramp 0..4 with exactly four grant cycles.
  task automatic grant_run(input string tag);
    int g;
    g = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      check({tag, "_credits"}, 64'(credits), 64'(g));
      if (lcrdv) g++;
    end
    check({tag, "_grants"}, 64'(g), 64'd4);
    check({tag, "_lcrdv_off"}, 64'(lcrdv), 64'd0);
  endtask

  always @(negedge clock) begin
    memreq_t e;
    if (!reset && valid && ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("pop_txnid", 64'(txnid), 64'(e.txnid));
        check("pop_addr", 64'(addr), 64'(e.addr));
        check("pop_size", 64'(size), 64'(e.size));
        check("pop_srcid", 64'(srcid), 64'(e.srcid));
        check("pop_rnid", 64'(rnid), 64'(e.returnnid));
        check("pop_eca", 64'(eca), 64'(e.expcompack));
      end
    end
  end

  initial begin
    ncmp     = 0;
    nfail    = 0;
    reset    = 1'b1;
    flit     = '0;
    flitv    = 1'b0;
    flitpend = 1'b0;
    ready    = 1'b0;
    repeat (3) step();
    check("rst_lcrdv", 64'(lcrdv), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_credits", 64'(credits), 64'd0);
    check("rst_errs", 64'({e_cred, e_tgt, e_op}), 64'd0);

    reset = 1'b0;
    grant_run("init");

    for (int i = 0; i < 4; i++)
      send(7'h20, 6'h04, 3'd6, 8'(i),
           48'h1000 + 48'(64 * i), 7'h00, 1'b0, 1'b1);
    check("fill_credits", 64'(credits), 64'd0);
    check("fill_valid", 64'(valid), 64'd1);
    check("fill_head", 64'(txnid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fill_nogrant", 64'(lcrdv), 64'd0);
    end

    ready = 1'b1;
    step();
    check("pop_regrant", 64'(lcrdv), 64'd1);
    repeat (3) step();
    ready = 1'b0;
    check("drain_valid", 64'(valid), 64'd0);
    step();
    check("drain_credits", 64'(credits), 64'd4);
    check("drain_sb", 64'(sb.size()), 64'd0);

    send(7'h20, 6'h04, 3'd6, 8'h10, 48'h2000,
         7'h05, 1'b1, 1'b1);
    check("dmt_valid", 64'(valid), 64'd1);
    check("dmt_rnid", 64'(rnid), 64'h05);
    check("dmt_eca", 64'(eca), 64'd1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    repeat (2) step();
    check("dmt_credits", 64'(credits), 64'd4);

    send(7'h20, 6'h00, 3'd0, 8'h00, 48'h0,
         7'h00, 1'b0, 1'b0);
    check("lret_credits", 64'(credits), 64'd3);
    check("lret_valid", 64'(valid), 64'd0);
    check("lret_grant", 64'(lcrdv), 64'd1);
    send(7'h20, 6'h00, 3'd0, 8'h00, 48'h0,
         7'h00, 1'b0, 1'b0);
    check("coinc_credits", 64'(credits), 64'd3);
    step();
    check("lret_back", 64'(credits), 64'd4);

    send(7'h11, 6'h04, 3'd6, 8'h30, 48'h3000,
         7'h00, 1'b0, 1'b0);
    check("tgt_err", 64'({e_cred, e_tgt, e_op}), 64'b010);
    check("tgt_valid", 64'(valid), 64'd0);
    check("tgt_credits", 64'(credits), 64'd3);
    repeat (2) step();
    send(7'h20, 6'h08, 3'd6, 8'h31, 48'h3000,
         7'h00, 1'b0, 1'b0);
    check("op_err", 64'({e_cred, e_tgt, e_op}), 64'b001);
    check("op_valid", 64'(valid), 64'd0);
    check("op_credits", 64'(credits), 64'd3);
    repeat (2) step();
    send(7'h20, 6'h04, 3'd7, 8'h32, 48'h3000,
         7'h00, 1'b0, 1'b0);
    check("sz_err", 64'({e_cred, e_tgt, e_op}), 64'b001);
    check("sz_valid", 64'(valid), 64'd0);
    check("sz_credits", 64'(credits), 64'd3);
    repeat (2) step();
    check("bad_back", 64'(credits), 64'd4);

    for (int i = 0; i < 4; i++)
      send(7'h20, 6'h04, 3'd3, 8'h20 + 8'(i),
           48'h4000 + 48'(64 * i), 7'h02, 1'b0, 1'b1);
    send(7'h20, 6'h04, 3'd3, 8'h77, 48'h5000,
         7'h00, 1'b0, 1'b0);
    check("cred_err", 64'({e_cred, e_tgt, e_op}), 64'b100);
    check("cred_credits", 64'(credits), 64'd0);
    check("cred_head", 64'(txnid), 64'h20);
    check("cred_lcrdv", 64'(lcrdv), 64'd0);

    ready = 1'b1;
    step();
    ready = 1'b0;
    reset = 1'b1;
    sb.delete();
    step();
    check("mid_rst_valid", 64'(valid), 64'd0);
    check("mid_rst_credits", 64'(credits), 64'd0);
    check("mid_rst_lcrdv", 64'(lcrdv), 64'd0);
    reset = 1'b0;
    grant_run("rerun");
    check("rerun_valid", 64'(valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/snf_rxreq.md
# snf_rxreq

SN-F request-channel receiver: the far end of the HN-F TXREQ link. Grants REQ-channel L-credits to the HN-F, accepts ReadNoSnp flits (including DMT requests carrying ReturnNID), buffers them in a credit-sized FIFO and presents them to the SN-F memory model over a valid/ready interface. Link-credit-return flits are absorbed. Malformed or illegal flits are dropped and flagged.

## Interface
Parameters:
- NUM_CREDITS, 4: REQ L-credits issued and FIFO depth; legal range 1..15.
- SNF_ID, 7'h20: node ID of this SN-F; flits with any other TgtID are rejected.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- RXREQFLIT  in  reqflit_t  incoming request flit.
- RXREQFLITV  in  1  flit valid; each cycle high consumes one L-credit.
- RXREQFLITPEND  in  1  early flit indication; informational only, ignored.
- RXREQLCRDV  out  1  one L-credit granted per cycle high.
- mem_req_valid  out  1  FIFO head valid.
- mem_req_ready  in  1  memory model accepts head.
- mem_req_addr  out  48  head Addr.
- mem_req_size  out  3  head Size.
- mem_req_txnid  out  8  head TxnID.
- mem_req_srcid  out  7  head SrcID (HN-F).
- mem_req_returnnid  out  7  head StashNID_ReturnNID (DMT data target).
- mem_req_expcompack  out  1  head ExpCompAck.
- err_credit  out  1  one-cycle pulse: flit received while no credit outstanding.
- err_tgtid  out  1  one-cycle pulse: TgtID != SNF_ID.
- err_opcode  out  1  one-cycle pulse: unsupported opcode or Size > 3'd6.
- credits_out  out  4  credits currently held by the HN-F.

## Operation
- State: tx_credits (credits held by the transmitter, 0..NUM_CREDITS), FIFO of NUM_CREDITS entries with count, rd/wr pointers wrapping modulo NUM_CREDITS.
- Credit grant: RXREQLCRDV is a register; next value = 1 iff tx_credits_next + count_next < NUM_CREDITS. tx_credits increments at the end of every cycle with RXREQLCRDV=1.
- Flit decode when RXREQFLITV=1, priority order:
  - tx_credits==0 (after counting a same-cycle grant as not yet held): err_credit, drop, no counter change.
  - Otherwise tx_credits decrements (a same-cycle grant nets to zero).
  - Opcode 6'h00 (LCrdReturn): credit returned, no FIFO write, no error.
  - TgtID != SNF_ID: err_tgtid, drop.
  - Opcode != 6'h04 (ReadNoSnp) or Size==3'd7: err_opcode, drop.
  - Else push {Addr, Size, TxnID, SrcID, StashNID_ReturnNID, ExpCompAck}.
- Pop when mem_req_valid & mem_req_ready. Simultaneous push and pop: count unchanged, both pointers advance.
- FIFO cannot overflow under correct credit use; a push at count==NUM_CREDITS is impossible because err_credit fires first.
- credits_out = tx_credits.

## Timing
- Reset: RXREQLCRDV=0, mem_req_valid=0, all err_*=0, credits_out=0, FIFO empty, pointers 0. Reset mid-operation discards all buffered requests and outstanding credits.
- First cycle after reset release: RXREQLCRDV=1; credits are granted on NUM_CREDITS consecutive cycles, then RXREQLCRDV=0.
- Accepted flit in cycle N: mem_req_valid and head fields valid in N+1 (first-word fall-through from the registered FIFO).
- Pop in cycle N frees a slot; RXREQLCRDV=1 in N+1.
- err_* pulses are asserted in N+1 for a flit in cycle N.
- Head fields are stable while mem_req_valid=1 and mem_req_ready=0.

## Test plan
- Reset release, no traffic: RXREQLCRDV high for exactly 4 cycles, credits_out goes 1,2,3,4 and holds at 4.
- Four ReadNoSnp flits (TgtID 7'h20, TxnID 0..3, Addr 0x1000+0x40*i) with ready=0: credits_out=0, no further credits. Ready=1: pops in order TxnID 0,1,2,3, and one credit is re-granted per pop, one cycle later.
- ReadNoSnp with ReturnNID 7'h05, ExpCompAck=1: mem_req_returnnid=7'h05 and mem_req_expcompack=1 in the cycle after the flit.
- LCrdReturn flit (opcode 0): credits_out decrements by 1, no mem_req_valid, credit re-granted next cycle.
- Bad flits: TgtID 7'h11 gives err_tgtid; opcode 6'h08 gives err_opcode; Size 7 gives err_opcode. Each consumes a credit and nothing is pushed.
- Flit with credits_out=0 gives err_credit and no count change. Flit coinciding with a grant leaves credits_out unchanged. Reset asserted with 3 entries queued: mem_req_valid=0 next cycle, credits re-issued from 0.
